// File: rtl/ept_uc_in_dist.sv
// ept_uc_in_dist: fans the Active Transfer library input bus out to N user modules.
// Trigger strobes become one-cycle pulses; transfer bytes are queued in a per-module FIFO.
module ept_uc_in_dist #(
  parameter int N     = 1,
  parameter int DEPTH = 4
) (
  input  logic           CLK_66,
  input  logic           RST_N,
  input  logic [21:0]    uc_in,
  output logic [N*8-1:0] trig_m,
  output logic [N*8-1:0] data_m,
  output logic [N-1:0]   data_valid_m,
  input  logic [N-1:0]   data_ready_m,
  output logic [N-1:0]   overflow_m,
  output logic [7:0]     bad_addr_cnt,
  output logic           uc_in_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] BUSY_CNT = CW'(DEPTH - 1);

  logic [7:0]     s1_payload_q, s1_payload_d;
  logic [2:0]     s1_addr_q, s1_addr_d;
  logic           s1_trig_q, s1_trig_d;
  logic           s1_xfer_q, s1_xfer_d;

  logic [N*8-1:0] trig_q, trig_d;
  logic [7:0]     bad_cnt_q, bad_cnt_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   ovf_q, ovf_d;

  logic [AW-1:0]  wr_ptr_q [N];
  logic [AW-1:0]  wr_ptr_d [N];
  logic [AW-1:0]  rd_ptr_q [N];
  logic [AW-1:0]  rd_ptr_d [N];
  logic [CW-1:0]  count_q  [N];
  logic [CW-1:0]  count_d  [N];
  logic [7:0]     mem_q    [N][DEPTH];
  logic [7:0]     mem_d    [N][DEPTH];

  logic           s1_strobe;
  logic           s1_addr_ok;
  logic [N-1:0]   push_req;
  logic [N-1:0]   push_ok;
  logic [N-1:0]   pop;
  logic [N-1:0]   full;

  logic           unused_rsvd;
  assign unused_rsvd = ^uc_in[21:13];

  always_comb begin
    s1_payload_d = uc_in[7:0];
    s1_addr_d    = uc_in[10:8];
    s1_trig_d    = uc_in[11];
    s1_xfer_d    = uc_in[12];
  end

  // Second stage: route the registered strobe to its owner, or count it as a bad address.
  always_comb begin
    s1_strobe  = s1_trig_q | s1_xfer_q;
    s1_addr_ok = ({1'b0, s1_addr_q} < 4'(N));
    trig_d     = '0;
    push_req   = '0;
    for (int i = 0; i < N; i++) begin
      if (s1_addr_ok && (s1_addr_q == 3'(i))) begin
        if (s1_trig_q) begin
          trig_d[i*8 +: 8] = s1_payload_q;
        end
        push_req[i] = s1_xfer_q;
      end
    end
    bad_cnt_d = bad_cnt_q;
    if (s1_strobe && !s1_addr_ok && (bad_cnt_q != 8'hFF)) begin
      bad_cnt_d = bad_cnt_q + 8'd1;
    end
  end

  // A push into a full FIFO still lands if the head leaves on the same edge.
  always_comb begin
    mem_d   = mem_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    pop     = '0;
    full    = '0;
    push_ok = '0;
    for (int i = 0; i < N; i++) begin
      pop[i]      = (count_q[i] != '0) && data_ready_m[i];
      full[i]     = (count_q[i] == FULL_CNT);
      push_ok[i]  = push_req[i] && (!full[i] || pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push_ok[i]) begin
        mem_d[i][wr_ptr_q[i]] = s1_payload_q;
        wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
      end
      if (push_ok[i] && !pop[i]) begin
        count_d[i] = count_q[i] + CW'(1);
      end else if (pop[i] && !push_ok[i]) begin
        count_d[i] = count_q[i] - CW'(1);
      end
      if (push_req[i] && full[i] && !pop[i]) begin
        ovf_d[i] = 1'b1;
      end
      if (count_d[i] >= BUSY_CNT) begin
        busy_d = 1'b1;
      end
    end
  end

  always_comb begin
    trig_m       = trig_q;
    overflow_m   = ovf_q;
    bad_addr_cnt = bad_cnt_q;
    uc_in_busy   = busy_q;
    data_m       = '0;
    data_valid_m = '0;
    for (int i = 0; i < N; i++) begin
      if (count_q[i] != '0) begin
        data_valid_m[i]  = 1'b1;
        data_m[i*8 +: 8] = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  always_ff @(posedge CLK_66) begin
    if (!RST_N) begin
      s1_payload_q <= '0;
      s1_addr_q    <= '0;
      s1_trig_q    <= 1'b0;
      s1_xfer_q    <= 1'b0;
      trig_q       <= '0;
      bad_cnt_q    <= '0;
      busy_q       <= 1'b0;
      ovf_q        <= '0;
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      s1_payload_q <= s1_payload_d;
      s1_addr_q    <= s1_addr_d;
      s1_trig_q    <= s1_trig_d;
      s1_xfer_q    <= s1_xfer_d;
      trig_q       <= trig_d;
      bad_cnt_q    <= bad_cnt_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: the read side is gated by the count.
  always_ff @(posedge CLK_66) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ept_uc_in_dist.sv
// tb_ept_uc_in_dist: table-driven trigger vectors with a latency scoreboard for trig_m,
// plus hand-written FIFO fill/drain, overflow, saturation and mid-traffic reset sequences.
module tb_ept_uc_in_dist;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic [21:0]   uc_in;
  logic [N*8-1:0] trig_m;
  logic [N*8-1:0] data_m;
  logic [N-1:0]  data_valid_m;
  logic [N-1:0]  data_ready_m;
  logic [N-1:0]  overflow_m;
  logic [7:0]    bad_addr_cnt;
  logic          uc_in_busy;

  ept_uc_in_dist #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK_66       (clk),
    .RST_N        (rst_n),
    .uc_in        (uc_in),
    .trig_m       (trig_m),
    .data_m       (data_m),
    .data_valid_m (data_valid_m),
    .data_ready_m (data_ready_m),
    .overflow_m   (overflow_m),
    .bad_addr_cnt (bad_addr_cnt),
    .uc_in_busy   (uc_in_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] exp_trig;
  } sb_t;

  typedef struct {
    logic [2:0]  addr;
    logic        trig;
    logic        xfer;
    logic [7:0]  payload;
    logic [15:0] exp_trig;
  } vec_t;

  sb_t        trig_sb[$];
  logic [7:0] fifo0_exp[$];
  vec_t       vecs[10];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cycle = 0;

  // Reserved bits are deliberately non-zero so that ignoring them is exercised.
  function automatic logic [21:0] mk(input logic [2:0] addr, input logic trig,
                                     input logic xfer, input logic [7:0] payload);
    return {9'h1A5, xfer, trig, addr, payload};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // A reset edge discards everything in flight, so pending trigger expectations become zero.
  task automatic tick();
    logic rst_at_edge;
    sb_t  ent;
    rst_at_edge = rst_n;
    @(posedge clk);
    cycle++;
    if (!rst_at_edge) begin
      foreach (trig_sb[j]) begin
        if (trig_sb[j].due <= cycle + 1) trig_sb[j].exp_trig = '0;
      end
    end
    #1;
    while (trig_sb.size() > 0 && trig_sb[0].due == cycle) begin
      ent = trig_sb.pop_front();
      checkOutput("trig_m", 32'(trig_m), 32'(ent.exp_trig));
    end
  endtask

  task automatic applyStimulus(input logic [21:0] uc, input logic [15:0] exp_trig);
    sb_t ent;
    uc_in        = uc;
    ent.due      = cycle + 2;
    ent.exp_trig = exp_trig;
    trig_sb.push_back(ent);
    tick();
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus(mk(3'd0, 1'b0, 1'b0, 8'h00), 16'h0000);
  endtask

  task automatic push0(input logic [7:0] b, input bit expect_kept);
    if (expect_kept) fifo0_exp.push_back(b);
    applyStimulus(mk(3'd0, 1'b0, 1'b1, b), 16'h0000);
  endtask

  task automatic drain0();
    logic [7:0] b;
    while (fifo0_exp.size() > 0) begin
      b = fifo0_exp.pop_front();
      checkOutput("drain_valid0", 32'(data_valid_m[0]), 32'd1);
      checkOutput("drain_data0", 32'(data_m[7:0]), 32'(b));
      data_ready_m[0] = 1'b1;
      idleCycles(1);
    end
    checkOutput("drained_valid", 32'(data_valid_m), 32'd0);
    checkOutput("drained_data", 32'(data_m), 32'd0);
    data_ready_m[0] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{3'd1, 1'b1, 1'b0, 8'hA5, 16'hA500};
    vecs[1] = '{3'd0, 1'b0, 1'b0, 8'h00, 16'h0000};
    vecs[2] = '{3'd0, 1'b1, 1'b0, 8'h3C, 16'h003C};
    vecs[3] = '{3'd1, 1'b1, 1'b0, 8'hFF, 16'hFF00};
    vecs[4] = '{3'd0, 1'b1, 1'b0, 8'h01, 16'h0001};
    vecs[5] = '{3'd5, 1'b1, 1'b0, 8'h99, 16'h0000};
    vecs[6] = '{3'd2, 1'b1, 1'b1, 8'h42, 16'h0000};
    vecs[7] = '{3'd7, 1'b0, 1'b1, 8'hE7, 16'h0000};
    vecs[8] = '{3'd1, 1'b1, 1'b1, 8'h5A, 16'h5A00};
    vecs[9] = '{3'd0, 1'b0, 1'b0, 8'h00, 16'h0000};

    rst_n        = 1'b0;
    uc_in        = '0;
    data_ready_m = '0;

    // Power-on reset held for three edges
    idleCycles(3);
    checkOutput("rst_trig", 32'(trig_m), 32'd0);
    checkOutput("rst_data", 32'(data_m), 32'd0);
    checkOutput("rst_valid", 32'(data_valid_m), 32'd0);
    checkOutput("rst_ovf", 32'(overflow_m), 32'd0);
    checkOutput("rst_bad", 32'(bad_addr_cnt), 32'd0);
    checkOutput("rst_busy", 32'(uc_in_busy), 32'd0);
    rst_n = 1'b1;
    idleCycles(1);

    // Trigger vectors, bad addresses and a combined trigger+transfer
    for (int v = 0; v < 10; v++) begin
      applyStimulus(mk(vecs[v].addr, vecs[v].trig, vecs[v].xfer, vecs[v].payload), vecs[v].exp_trig);
    end
    idleCycles(2);
    checkOutput("bad_cnt_3", 32'(bad_addr_cnt), 32'd3);
    checkOutput("m1_valid", 32'(data_valid_m), 32'h2);
    checkOutput("m1_data", 32'(data_m), 32'h5A00);
    checkOutput("m1_busy", 32'(uc_in_busy), 32'd0);
    checkOutput("m1_ovf", 32'(overflow_m), 32'd0);
    data_ready_m[1] = 1'b1;
    idleCycles(1);
    checkOutput("m1_popped_valid", 32'(data_valid_m), 32'd0);
    checkOutput("m1_popped_data", 32'(data_m), 32'd0);
    data_ready_m[1] = 1'b0;

    // Full FIFO: a push landing on the same edge as a pop is accepted
    push0(8'h11, 1'b1);
    push0(8'h22, 1'b1);
    push0(8'h33, 1'b1);
    push0(8'h44, 1'b1);
    idleCycles(2);
    checkOutput("full_busy", 32'(uc_in_busy), 32'd1);
    checkOutput("full_head", 32'(data_m[7:0]), 32'(fifo0_exp.pop_front()));
    applyStimulus(mk(3'd0, 1'b0, 1'b1, 8'h66), 16'h0000);
    data_ready_m[0] = 1'b1;
    fifo0_exp.push_back(8'h66);
    idleCycles(1);
    checkOutput("simpop_ovf", 32'(overflow_m), 32'd0);
    checkOutput("simpop_busy", 32'(uc_in_busy), 32'd1);
    drain0();
    checkOutput("simpop_busy_after", 32'(uc_in_busy), 32'd0);

    // Fill past capacity with the consumer stalled
    push0(8'h11, 1'b1);
    push0(8'h22, 1'b1);
    push0(8'h33, 1'b1);
    checkOutput("busy_at_2", 32'(uc_in_busy), 32'd0);
    push0(8'h44, 1'b1);
    checkOutput("busy_at_3", 32'(uc_in_busy), 32'd1);
    push0(8'h55, 1'b0);
    checkOutput("ovf_before_drop", 32'(overflow_m), 32'd0);
    idleCycles(1);
    checkOutput("ovf_after_drop", 32'(overflow_m), 32'h1);
    checkOutput("busy_full", 32'(uc_in_busy), 32'd1);
    idleCycles(1);
    checkOutput("fill_valid", 32'(data_valid_m), 32'h1);
    drain0();
    checkOutput("ovf_sticky", 32'(overflow_m), 32'h1);
    checkOutput("busy_empty", 32'(uc_in_busy), 32'd0);

    // Saturating bad-address counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(mk(3'd5, i[0], ~i[0], 8'(i)), 16'h0000);
    end
    idleCycles(2);
    checkOutput("bad_cnt_sat", 32'(bad_addr_cnt), 32'd255);
    checkOutput("bad_no_valid", 32'(data_valid_m), 32'd0);
    checkOutput("bad_ovf_same", 32'(overflow_m), 32'h1);

    // Reset with bytes queued and a trigger still in the pipeline
    push0(8'hAA, 1'b1);
    push0(8'hBB, 1'b1);
    idleCycles(2);
    checkOutput("pre_rst_valid", 32'(data_valid_m), 32'h1);
    applyStimulus(mk(3'd1, 1'b1, 1'b0, 8'h77), 16'h7700);
    rst_n = 1'b0;
    idleCycles(1);
    rst_n = 1'b0;
    fifo0_exp.delete();
    checkOutput("midrst_valid", 32'(data_valid_m), 32'd0);
    checkOutput("midrst_data", 32'(data_m), 32'd0);
    checkOutput("midrst_ovf", 32'(overflow_m), 32'd0);
    checkOutput("midrst_bad", 32'(bad_addr_cnt), 32'd0);
    checkOutput("midrst_busy", 32'(uc_in_busy), 32'd0);
    rst_n = 1'b1;
    idleCycles(1);

    // First strobes after reset behave normally
    applyStimulus(mk(3'd0, 1'b1, 1'b0, 8'hC3), 16'h00C3);
    applyStimulus(mk(3'd1, 1'b0, 1'b1, 8'hD4), 16'h0000);
    idleCycles(2);
    checkOutput("post_rst_valid", 32'(data_valid_m), 32'h2);
    checkOutput("post_rst_data", 32'(data_m), 32'hD400);
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
